// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the 5-stage pipeline: counts owed
// write-backs, raises the decode stall on RAW / WAW-saturation hazards, and publishes availability flags.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        validD,
    input  logic        regWriteD,
    input  logic        regDstD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic        useRsD,
    input  logic        useRtD,
    input  logic        regWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic        killValid,
    input  logic [4:0]  killReg,
    output logic        stallD,
    output logic [31:0] readyFlags,
    output logic        errUnderflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r [32];
    logic [CNT_W-1:0] cntNext_s [32];
    logic [31:0]      readyNext_s;
    logic             underAny_s;
    logic [4:0]       dest_s;
    logic             rsHaz_s;
    logic             rtHaz_s;
    logic             satHaz_s;
    logic             issue_s;

    // Hazard detection and decode stall; a write landing this cycle acts as a bypass.
    always_comb begin
        dest_s   = regDstD ? RdD : RtD;
        rsHaz_s  = useRsD && (RsD != 5'd0) && (cnt_r[RsD] != CNT_ZERO) &&
                   !((cnt_r[RsD] == CNT_ONE) && regWriteW && (WriteRegW == RsD));
        rtHaz_s  = useRtD && (RtD != 5'd0) && (cnt_r[RtD] != CNT_ZERO) &&
                   !((cnt_r[RtD] == CNT_ONE) && regWriteW && (WriteRegW == RtD));
        satHaz_s = validD && regWriteD && (dest_s != 5'd0) && (cnt_r[dest_s] == CNT_MAX) &&
                   !((regWriteW && (WriteRegW == dest_s)) || (killValid && (killReg == dest_s)));
        stallD   = validD && (rsHaz_s || rtHaz_s || satHaz_s);
        issue_s  = validD && regWriteD && !stallD && (dest_s != 5'd0);
    end

    // Next counts: decrements saturate at zero (flagging underflow) before the issue increment.
    always_comb begin
        underAny_s  = 1'b0;
        readyNext_s = 32'd0;
        for (int n = 0; n < 32; n++) begin
            cntNext_s[n] = cnt_r[n];
            if (n == 0) begin
                cntNext_s[n] = CNT_ZERO;
            end else begin
                if (regWriteW && (WriteRegW == 5'(n))) begin
                    if (cntNext_s[n] == CNT_ZERO) begin
                        underAny_s = 1'b1;
                    end else begin
                        cntNext_s[n] = cntNext_s[n] - CNT_ONE;
                    end
                end else begin
                    cntNext_s[n] = cntNext_s[n];
                end
                if (killValid && (killReg == 5'(n))) begin
                    if (cntNext_s[n] == CNT_ZERO) begin
                        underAny_s = 1'b1;
                    end else begin
                        cntNext_s[n] = cntNext_s[n] - CNT_ONE;
                    end
                end else begin
                    cntNext_s[n] = cntNext_s[n];
                end
                if (issue_s && (dest_s == 5'(n))) begin
                    cntNext_s[n] = cntNext_s[n] + CNT_ONE;
                end else begin
                    cntNext_s[n] = cntNext_s[n];
                end
            end
            readyNext_s[n] = (cntNext_s[n] == CNT_ZERO);
        end
    end

    // State registers: counters, availability flags and sticky underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 32; n++) begin
                cnt_r[n] <= CNT_ZERO;
            end
            readyFlags   <= 32'hFFFF_FFFF;
            errUnderflow <= 1'b0;
        end else begin
            for (int n = 0; n < 32; n++) begin
                cnt_r[n] <= cntNext_s[n];
            end
            readyFlags   <= readyNext_s;
            errUnderflow <= errUnderflow | underAny_s;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W = 2).
module tb_reg_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        validD;
    logic        regWriteD;
    logic        regDstD;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdD;
    logic        useRsD;
    logic        useRtD;
    logic        regWriteW;
    logic [4:0]  WriteRegW;
    logic        killValid;
    logic [4:0]  killReg;
    logic        stallD;
    logic [31:0] readyFlags;
    logic        errUnderflow;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .validD(validD), .regWriteD(regWriteD),
        .regDstD(regDstD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .useRsD(useRsD),
        .useRtD(useRtD), .regWriteW(regWriteW), .WriteRegW(WriteRegW),
        .killValid(killValid), .killReg(killReg), .stallD(stallD),
        .readyFlags(readyFlags), .errUnderflow(errUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        validD = 1'b0; regWriteD = 1'b0; regDstD = 1'b0;
        RsD = 5'd0; RtD = 5'd0; RdD = 5'd0; useRsD = 1'b0; useRtD = 1'b0;
        regWriteW = 1'b0; WriteRegW = 5'd0; killValid = 1'b0; killReg = 5'd0;
    endtask

    // Decode instruction writing register r through the Rd field.
    task automatic issueRd(input logic [4:0] r);
        idle();
        validD = 1'b1; regWriteD = 1'b1; regDstD = 1'b1; RdD = r;
    endtask

    initial begin
        reset_n   = 1'b0;
        validD    = 1'($urandom);  regWriteD = 1'($urandom); regDstD = 1'($urandom);
        RsD       = 5'($urandom);  RtD = 5'($urandom); RdD = 5'($urandom);
        useRsD    = 1'($urandom);  useRtD = 1'($urandom);
        regWriteW = 1'($urandom);  WriteRegW = 5'($urandom);
        killValid = 1'($urandom);  killReg = 5'($urandom);
        tick(); tick();
        chk("reset_ready_in_reset", readyFlags, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        idle();
        tick();
        chk("reset_ready", readyFlags, 32'hFFFF_FFFF);
        chk("reset_err", {31'd0, errUnderflow}, 32'd0);
        chk("reset_stall", {31'd0, stallD}, 32'd0);

        // RAW on $3
        issueRd(5'd3);
        #1 chk("raw_issue_nostall", {31'd0, stallD}, 32'd0);
        tick();
        chk("raw_ready3_low", readyFlags, 32'hFFFF_FFF7);
        idle(); useRsD = 1'b1; RsD = 5'd3;
        #1 chk("raw_bubble_nostall", {31'd0, stallD}, 32'd0);
        validD = 1'b1;
        #1 chk("raw_stall_c1", {31'd0, stallD}, 32'd1);
        tick();
        chk("raw_stall_c2", {31'd0, stallD}, 32'd1);
        tick();
        regWriteW = 1'b1; WriteRegW = 5'd3;
        #1 chk("raw_bypass", {31'd0, stallD}, 32'd0);
        tick();
        chk("raw_ready3_back", readyFlags, 32'hFFFF_FFFF);

        // Rt hazard on $6, cleared by a flush
        issueRd(5'd6);
        tick();
        idle(); validD = 1'b1; useRtD = 1'b1; RtD = 5'd6;
        #1 chk("rt_stall", {31'd0, stallD}, 32'd1);
        useRtD = 1'b0;
        #1 chk("rt_unused_nostall", {31'd0, stallD}, 32'd0);
        idle(); killValid = 1'b1; killReg = 5'd6;
        tick();
        chk("rt_kill_ready", readyFlags, 32'hFFFF_FFFF);

        // WAW saturation on $5 via Rt destination
        for (int i = 0; i < 3; i++) begin
            idle(); validD = 1'b1; regWriteD = 1'b1; RtD = 5'd5;
            #1 chk("waw_fill_nostall", {31'd0, stallD}, 32'd0);
            tick();
        end
        #1 chk("waw_sat_stall", {31'd0, stallD}, 32'd1);
        tick();
        chk("waw_sat_stall2", {31'd0, stallD}, 32'd1);
        chk("waw_ready5_low", readyFlags, 32'hFFFF_FFDF);
        regWriteW = 1'b1; WriteRegW = 5'd5;
        #1 chk("waw_release", {31'd0, stallD}, 32'd0);
        tick();
        idle(); regWriteW = 1'b1; WriteRegW = 5'd5;
        tick();
        chk("waw_after_wb1", readyFlags, 32'hFFFF_FFDF);
        tick();
        chk("waw_after_wb2", readyFlags, 32'hFFFF_FFDF);
        tick();
        chk("waw_after_wb3", readyFlags, 32'hFFFF_FFFF);
        chk("waw_err", {31'd0, errUnderflow}, 32'd0);

        // Simultaneous events on $7
        issueRd(5'd7);
        tick();
        issueRd(5'd7); regWriteW = 1'b1; WriteRegW = 5'd7;
        #1 chk("sim_issue_wb_nostall", {31'd0, stallD}, 32'd0);
        tick();
        chk("sim_issue_wb_cnt1", readyFlags, 32'hFFFF_FF7F);
        issueRd(5'd7);
        tick();
        issueRd(5'd7); regWriteW = 1'b1; WriteRegW = 5'd7; killValid = 1'b1; killReg = 5'd7;
        tick();
        chk("sim_triple_cnt1", readyFlags, 32'hFFFF_FF7F);
        idle(); regWriteW = 1'b1; WriteRegW = 5'd7;
        tick();
        chk("sim_drain", readyFlags, 32'hFFFF_FFFF);
        chk("sim_err", {31'd0, errUnderflow}, 32'd0);

        // Register 0 is untracked
        issueRd(5'd0); useRsD = 1'b1; RsD = 5'd0;
        #1 chk("r0_nostall", {31'd0, stallD}, 32'd0);
        tick();
        chk("r0_ready", readyFlags, 32'hFFFF_FFFF);
        idle(); regWriteW = 1'b1; WriteRegW = 5'd0; killValid = 1'b1; killReg = 5'd0;
        tick();
        chk("r0_no_err", {31'd0, errUnderflow}, 32'd0);

        // Flush of $4
        issueRd(5'd4);
        tick();
        chk("flush_ready4_low", readyFlags, 32'hFFFF_FFEF);
        idle(); killValid = 1'b1; killReg = 5'd4;
        tick();
        chk("flush_ready4", readyFlags, 32'hFFFF_FFFF);
        idle(); validD = 1'b1; useRsD = 1'b1; RsD = 5'd4;
        #1 chk("flush_reader_nostall", {31'd0, stallD}, 32'd0);
        chk("flush_err", {31'd0, errUnderflow}, 32'd0);

        // Underflow on $9, sticky
        idle(); regWriteW = 1'b1; WriteRegW = 5'd9;
        tick();
        chk("under_set", {31'd0, errUnderflow}, 32'd1);
        chk("under_ready", readyFlags, 32'hFFFF_FFFF);
        idle();
        tick(); tick();
        chk("under_sticky", {31'd0, errUnderflow}, 32'd1);

        // Mid-operation reset discards pending counts
        issueRd(5'd10);
        tick();
        chk("mid_ready10_low", readyFlags, 32'hFFFF_FBFF);
        idle();
        reset_n = 1'b0;
        #1 chk("mid_reset_ready", readyFlags, 32'hFFFF_FFFF);
        chk("mid_reset_err", {31'd0, errUnderflow}, 32'd0);
        tick();
        reset_n = 1'b1;
        validD = 1'b1; useRsD = 1'b1; RsD = 5'd10;
        #1 chk("mid_reset_nostall", {31'd0, stallD}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
